// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply operand loader.
// Holds the default geometry (M x N times N x P, 8-bit words), the derived RAM word counts
// and the loader state encoding.
package mm_pkg;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefADepthBits = 9;
  localparam int unsigned DefBDepthBits = 9;
  localparam int unsigned DefM          = 64;
  localparam int unsigned DefN          = 8;
  localparam int unsigned DefP          = 4;

  localparam int unsigned A_WORDS = DefM * DefN;
  localparam int unsigned B_WORDS = DefN * DefP;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoadA  = 3'd1,
    StLoadB  = 3'd2,
    StRun    = 3'd3,
    StFinish = 3'd4
  } mm_state_e;

  // States in which the stream slave accepts beats.
  function automatic logic is_load_state(input mm_state_e st);
    return (st == StLoadA) || (st == StLoadB);
  endfunction

endpackage

// File: rtl/mm_wrap_counter.sv
// Wrapping beat counter used for the A and B RAM write addresses.
// Counts 0 .. Limit-1 on en_i and wraps to 0 after the terminal count.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset (count -> 0)
//   en_i     advance by one (wraps at Limit-1)
//   clr_i    force count to 0 (wins over en_i)
//   count_o  current count
//   tc_o     high while count_o == Limit-1
module mm_wrap_counter #(
  parameter int unsigned Width = 9,
  parameter int unsigned Limit = 512
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_d, count_q;
  logic             tc;

  assign tc = (count_q == Width'(Limit - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;

endmodule

// File: rtl/mm_stream_loader.sv
// Operand loader for the matrix-multiply core.
// Accepts one frame on an AXI-Stream slave (A: M*N words row-major, then B: N*P words
// row-major), writes the words into the A and B RAMs through registered write ports, then
// raises Start and waits for Done from the multiplier before pulsing frame_done.
//
// Optional feature macro: MM_LOADER_TLAST_CHECK_EN
//   defined     : tlast must be high on the last B beat and only there; otherwise the beat is
//                 dropped, load_err sets (sticky until reset) and the frame is abandoned.
//   not defined : tlast is ignored and load_err stays 0.
//
// Ports:
//   clk, resetn                        clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast   operand stream slave
//   A_write_en/address/data_in         A RAM write port (1-cycle registered)
//   B_write_en/address/data_in         B RAM write port (1-cycle registered)
//   Start, Done                        multiplier handshake (Start held until Done seen)
//   busy                               high in every state except idle
//   frame_done                         one-cycle pulse when the multiplier finishes
//   load_err                           sticky framing error
module mm_stream_loader
  import mm_pkg::*;
#(
  parameter int unsigned width        = DefWidth,
  parameter int unsigned A_depth_bits = DefADepthBits,
  parameter int unsigned B_depth_bits = DefBDepthBits,
  parameter int unsigned M            = DefM,
  parameter int unsigned N            = DefN,
  parameter int unsigned P            = DefP
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [width-1:0]        s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    A_write_en,
  output logic [A_depth_bits-1:0] A_write_address,
  output logic [width-1:0]        A_write_data_in,
  output logic                    B_write_en,
  output logic [B_depth_bits-1:0] B_write_address,
  output logic [width-1:0]        B_write_data_in,
  output logic                    Start,
  input  logic                    Done,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    load_err
);

  localparam int unsigned AWords = M * N;
  localparam int unsigned BWords = N * P;

  mm_state_e state_d, state_q;

  logic                    tready_d, tready_q;
  logic                    busy_d, busy_q;
  logic                    a_we_d, a_we_q;
  logic [A_depth_bits-1:0] a_addr_d, a_addr_q;
  logic [width-1:0]        a_data_d, a_data_q;
  logic                    b_we_d, b_we_q;
  logic [B_depth_bits-1:0] b_addr_d, b_addr_q;
  logic [width-1:0]        b_data_d, b_data_q;
  logic                    start_d, start_q;
  logic                    run_armed_d, run_armed_q;
  logic                    frame_done_d, frame_done_q;
  logic                    load_err_d, load_err_q;

  logic                    hs;
  logic                    frame_err;
  logic                    a_en, b_en;
  logic [A_depth_bits-1:0] a_cnt;
  logic [B_depth_bits-1:0] b_cnt;
  logic                    a_tc, b_tc;

  assign hs = s_axis_tvalid & tready_q;

`ifdef MM_LOADER_TLAST_CHECK_EN
  // tlast must coincide exactly with the final B beat.
  assign frame_err = hs && (s_axis_tlast != ((state_q == StLoadB) && b_tc));
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign frame_err    = 1'b0;
`endif

  assign a_en = hs && (state_q == StLoadA) && !frame_err;
  assign b_en = hs && (state_q == StLoadB) && !frame_err;

  mm_wrap_counter #(
    .Width (A_depth_bits),
    .Limit (AWords)
  ) u_a_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .en_i    (a_en),
    .clr_i   (frame_err),
    .count_o (a_cnt),
    .tc_o    (a_tc)
  );

  mm_wrap_counter #(
    .Width (B_depth_bits),
    .Limit (BWords)
  ) u_b_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .en_i    (b_en),
    .clr_i   (frame_err),
    .count_o (b_cnt),
    .tc_o    (b_tc)
  );

  always_comb begin
    state_d      = state_q;
    a_we_d       = 1'b0;
    a_addr_d     = a_addr_q;
    a_data_d     = a_data_q;
    b_we_d       = 1'b0;
    b_addr_d     = b_addr_q;
    b_data_d     = b_data_q;
    start_d      = start_q;
    frame_done_d = 1'b0;
    load_err_d   = load_err_q;
    // Done is only trusted once Start has been high for a full cycle.
    run_armed_d  = (state_q == StRun);

    unique case (state_q)
      StIdle: begin
        state_d = StLoadA;
      end
      StLoadA: begin
        if (hs) begin
          if (frame_err) begin
            state_d    = StIdle;
            load_err_d = 1'b1;
          end else begin
            a_we_d   = 1'b1;
            a_addr_d = a_cnt;
            a_data_d = s_axis_tdata;
            if (a_tc) begin
              state_d = StLoadB;
            end
          end
        end
      end
      StLoadB: begin
        if (hs) begin
          if (frame_err) begin
            state_d    = StIdle;
            load_err_d = 1'b1;
          end else begin
            b_we_d   = 1'b1;
            b_addr_d = b_cnt;
            b_data_d = s_axis_tdata;
            if (b_tc) begin
              // Start rises together with the final B write.
              state_d = StRun;
              start_d = 1'b1;
            end
          end
        end
      end
      StRun: begin
        if (run_armed_q && Done) begin
          state_d      = StFinish;
          start_d      = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        start_d = 1'b0;
      end
    endcase

    tready_d = is_load_state(state_d);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      tready_q     <= 1'b0;
      busy_q       <= 1'b0;
      a_we_q       <= 1'b0;
      a_addr_q     <= '0;
      a_data_q     <= '0;
      b_we_q       <= 1'b0;
      b_addr_q     <= '0;
      b_data_q     <= '0;
      start_q      <= 1'b0;
      run_armed_q  <= 1'b0;
      frame_done_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tready_q     <= tready_d;
      busy_q       <= busy_d;
      a_we_q       <= a_we_d;
      a_addr_q     <= a_addr_d;
      a_data_q     <= a_data_d;
      b_we_q       <= b_we_d;
      b_addr_q     <= b_addr_d;
      b_data_q     <= b_data_d;
      start_q      <= start_d;
      run_armed_q  <= run_armed_d;
      frame_done_q <= frame_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign s_axis_tready   = tready_q;
  assign A_write_en      = a_we_q;
  assign A_write_address = a_addr_q;
  assign A_write_data_in = a_data_q;
  assign B_write_en      = b_we_q;
  assign B_write_address = b_addr_q;
  assign B_write_data_in = b_data_q;
  assign Start           = start_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign load_err        = load_err_q;

endmodule

// File: tb/tb_mm_stream_loader.sv
// Directed bench for mm_stream_loader: RAM write monitor, Done responder, one task per scenario.
module tb_mm_stream_loader;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic       A_write_en;
  logic [8:0] A_write_address;
  logic [7:0] A_write_data_in;
  logic       B_write_en;
  logic [8:0] B_write_address;
  logic [7:0] B_write_data_in;
  logic       Start, Done, busy, frame_done, load_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mm_stream_loader dut (
    .clk             (clk),
    .resetn          (resetn),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .A_write_en      (A_write_en),
    .A_write_address (A_write_address),
    .A_write_data_in (A_write_data_in),
    .B_write_en      (B_write_en),
    .B_write_address (B_write_address),
    .B_write_data_in (B_write_data_in),
    .Start           (Start),
    .Done            (Done),
    .busy            (busy),
    .frame_done      (frame_done),
    .load_err        (load_err)
  );

  // Multiplier model: Done rises 100 cycles after Start and holds until Start falls.
  int done_cnt;
  always @(posedge clk) begin
    if (Start !== 1'b1) begin
      done_cnt <= 0;
      Done     <= 1'b0;
    end else if (done_cnt >= 100) begin
      Done <= 1'b1;
    end else begin
      done_cnt <= done_cnt + 1;
    end
  end

  // RAM and handshake monitor, sampled on the falling edge.
  logic [7:0] a_mem [512];
  logic       a_wr  [512];
  logic [7:0] b_mem [32];
  int   wr_count, first_a_addr, fd_count, fd_long, tready_run, start_rises, min_gap, low_cnt;
  logic mon_clr = 1'b0;
  logic start_prev, fd_prev;

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 512; i++) begin
        a_mem[i] = 8'h00;
        a_wr[i]  = 1'b0;
      end
      for (int i = 0; i < 32; i++) b_mem[i] = 8'h00;
      wr_count = 0; first_a_addr = -1; fd_count = 0; fd_long = 0; tready_run = 0;
      start_rises = 0; min_gap = 1000000; low_cnt = 0;
      start_prev = (Start === 1'b1); fd_prev = 1'b0;
    end else begin
      if (A_write_en === 1'b1) begin
        if (first_a_addr < 0) first_a_addr = int'(A_write_address);
        a_mem[A_write_address] = A_write_data_in;
        a_wr[A_write_address]  = 1'b1;
        wr_count++;
      end
      if (B_write_en === 1'b1) begin
        if (B_write_address < 9'd32) b_mem[B_write_address[4:0]] = B_write_data_in;
        wr_count++;
      end
      if (frame_done === 1'b1 && fd_prev) fd_long++;
      if (frame_done === 1'b1 && !fd_prev) fd_count++;
      fd_prev = (frame_done === 1'b1);
      if (Start === 1'b1 && s_axis_tready === 1'b1) tready_run++;
      if (Start === 1'b1 && !start_prev) begin
        start_rises++;
        if (low_cnt < min_gap) min_gap = low_cnt;
        low_cnt = 0;
      end
      if (Start !== 1'b1) low_cnt++;
      start_prev = (Start === 1'b1);
    end
  end

  task automatic clear_mon();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Streams beats 0..last_beat (A beat i = i, B beat j = 0x80|j); tlast on 543 and err_beat.
  // Returns on the falling edge after the last accepted beat with tvalid low.
  task automatic stream_frame(input bit gaps, input int err_beat, input int last_beat);
    int   beat = 0;
    int   cyc  = 0;
    logic valid, acc;
    forever begin
      @(negedge clk);
      if (beat > last_beat || cyc >= 5000) break;
      valid         = !gaps || (cyc % 2 == 0);
      s_axis_tvalid = valid;
      s_axis_tdata  = (beat < 512) ? 8'(beat) : (8'h80 | 8'(beat - 512));
      s_axis_tlast  = (beat == 543) || (beat == err_beat);
      acc           = valid && (s_axis_tready === 1'b1);
      @(posedge clk);
      if (acc) beat++;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++;
    if (beat <= last_beat) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d beats, required %0d", beat, last_beat + 1);
    end
  endtask

  // Waits (bounded) for frame_done; returns on the falling edge where it is seen.
  task automatic wait_frame_done(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_done_timeout: frame_done=%b, required 1", tag, frame_done);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks += 7;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL %s_tready: %b, required 0", tag, s_axis_tready); end
    if (A_write_en !== 1'b0) begin errors++; $display("FAIL %s_a_we: %b, required 0", tag, A_write_en); end
    if (B_write_en !== 1'b0) begin errors++; $display("FAIL %s_b_we: %b, required 0", tag, B_write_en); end
    if (Start !== 1'b0) begin errors++; $display("FAIL %s_start: %b, required 0", tag, Start); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: %b, required 0", tag, busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL %s_frame_done: %b, required 0", tag, frame_done); end
    if (load_err !== 1'b0) begin errors++; $display("FAIL %s_load_err: %b, required 0", tag, load_err); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("por");
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL load_a_tready: %b, required 1", s_axis_tready);
    end
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset");
    resetn = 1'b1;
  endtask

  task automatic test_continuous();
    clear_mon();
    stream_frame(1'b0, -1, 543);
    checks += 4;
    if (Start !== 1'b1) begin errors++; $display("FAIL start_rise: %b, required 1", Start); end
    if (B_write_en !== 1'b1) begin errors++; $display("FAIL last_b_we: %b, required 1", B_write_en); end
    if (B_write_address !== 9'd31) begin
      errors++; $display("FAIL last_b_addr: %0d, required 31", B_write_address);
    end
    if (B_write_data_in !== 8'h9F) begin
      errors++; $display("FAIL last_b_data: %h, required 9f", B_write_data_in);
    end
    wait_frame_done("cont");
    checks += 2;
    if (Start !== 1'b0) begin errors++; $display("FAIL finish_start: %b, required 0", Start); end
    if (busy !== 1'b1) begin errors++; $display("FAIL finish_busy: %b, required 1", busy); end
    @(negedge clk);
    #1;
    checks += 6;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_width: %b, required 0", frame_done); end
    if (a_mem[511] !== 8'hFF) begin errors++; $display("FAIL a511: %h, required ff", a_mem[511]); end
    if (a_mem[37] !== 8'h25) begin errors++; $display("FAIL a37: %h, required 25", a_mem[37]); end
    if (b_mem[31] !== 8'h9F) begin errors++; $display("FAIL b31: %h, required 9f", b_mem[31]); end
    if (b_mem[0] !== 8'h80) begin errors++; $display("FAIL b0: %h, required 80", b_mem[0]); end
    if (wr_count !== 544) begin errors++; $display("FAIL cont_writes: %0d, required 544", wr_count); end
  endtask

  task automatic test_gaps();
    int bad = 0;
    clear_mon();
    stream_frame(1'b1, -1, 543);
    wait_frame_done("gaps");
    @(negedge clk);
    #1;
    for (int i = 0; i < 512; i++) if (a_mem[i] !== 8'(i)) bad++;
    for (int j = 0; j < 32; j++) if (b_mem[j] !== (8'h80 | 8'(j))) bad++;
    checks += 2;
    if (bad !== 0) begin errors++; $display("FAIL gaps_contents: %0d bad words, required 0", bad); end
    if (wr_count !== 544) begin errors++; $display("FAIL gaps_writes: %0d, required 544", wr_count); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    stream_frame(1'b0, -1, 200);
    // Present beat 201 while reset is asserted; it must not be written.
    resetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 8'd201;
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    checks += 2;
    if (A_write_en !== 1'b0) begin errors++; $display("FAIL rst_a_we: %b, required 0", A_write_en); end
    if (Start !== 1'b0) begin errors++; $display("FAIL rst_start: %b, required 0", Start); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_count !== 201) begin errors++; $display("FAIL rst_writes: %0d, required 201", wr_count); end
    clear_mon();
    stream_frame(1'b0, -1, 543);
    wait_frame_done("after_rst");
    @(negedge clk);
    #1;
    checks += 2;
    if (first_a_addr !== 0) begin errors++; $display("FAIL rst_first_addr: %0d, required 0", first_a_addr); end
    if (wr_count !== 544) begin errors++; $display("FAIL rst_frame_writes: %0d, required 544", wr_count); end
  endtask

  task automatic test_tlast();
    clear_mon();
`ifdef MM_LOADER_TLAST_CHECK_EN
    stream_frame(1'b0, 100, 100);
    repeat (200) @(negedge clk);
    #1;
    checks += 4;
    if (load_err !== 1'b1) begin errors++; $display("FAIL tlast_err: %b, required 1", load_err); end
    if (a_wr[100] !== 1'b0) begin errors++; $display("FAIL tlast_a100: %b, required 0", a_wr[100]); end
    if (wr_count !== 100) begin errors++; $display("FAIL tlast_writes: %0d, required 100", wr_count); end
    if (start_rises !== 0) begin errors++; $display("FAIL tlast_start: %0d, required 0", start_rises); end
    do_reset();
    checks++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL tlast_err_clr: %b, required 0", load_err); end
`else
    stream_frame(1'b0, 100, 543);
    wait_frame_done("tlast");
    @(negedge clk);
    #1;
    checks += 4;
    if (load_err !== 1'b0) begin errors++; $display("FAIL tlast_err: %b, required 0", load_err); end
    if (a_mem[100] !== 8'd100) begin errors++; $display("FAIL tlast_a100: %h, required 64", a_mem[100]); end
    if (wr_count !== 544) begin errors++; $display("FAIL tlast_writes: %0d, required 544", wr_count); end
    if (fd_count !== 1) begin errors++; $display("FAIL tlast_fd: %0d, required 1", fd_count); end
`endif
  endtask

  task automatic test_back_to_back();
    clear_mon();
    stream_frame(1'b0, -1, 543);
    stream_frame(1'b0, -1, 543);
    wait_frame_done("b2b");
    @(negedge clk);
    #1;
    checks += 5;
    if (fd_count !== 2) begin errors++; $display("FAIL b2b_fd_count: %0d, required 2", fd_count); end
    if (fd_long !== 0) begin errors++; $display("FAIL b2b_fd_long: %0d, required 0", fd_long); end
    if (tready_run !== 0) begin errors++; $display("FAIL b2b_tready_run: %0d, required 0", tready_run); end
    if (start_rises !== 2) begin errors++; $display("FAIL b2b_start_rises: %0d, required 2", start_rises); end
    if (min_gap < 2) begin errors++; $display("FAIL b2b_start_gap: %0d, required >=2", min_gap); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_reset_mid();
    test_tlast();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
